// File: rtl/ysyx_22051013_trap_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22051013_trap_pkg
// Shared definitions for the machine-mode trap/CSR sequencer:
//   - sequencer state enum
//   - csr_ctl one-hot command encodings {wr, rd, ecall, mret}
//   - CSR instruction op encodings
//   - machine-mode CSR numbers used by the sequencer
//   - mcause constants
// No ports (package only).
// ---------------------------------------------------------------------------
package ysyx_22051013_trap_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CSR_RD = 3'd1,
    S_CSR_WR = 3'd2,
    S_TRAP   = 3'd3,
    S_RET    = 3'd4,
    S_REDIR  = 3'd5
  } trap_state_e;

  // csr_ctl bit order is {wr, rd, ecall, mret}; never more than one set.
  localparam logic [3:0] CTL_NONE  = 4'b0000;
  localparam logic [3:0] CTL_WR    = 4'b1000;
  localparam logic [3:0] CTL_RD    = 4'b0100;
  localparam logic [3:0] CTL_ECALL = 4'b0010;
  localparam logic [3:0] CTL_MRET  = 4'b0001;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [63:0] MCAUSE_ECALL_M = 64'd11;
  localparam logic [63:0] MCAUSE_M_TIMER = 64'h8000_0000_0000_0007;

endpackage

// File: rtl/ysyx_22051013_csr_alu.sv
// ---------------------------------------------------------------------------
// ysyx_22051013_csr_alu
// Combinational write-value generator for Zicsr read-modify-write ops.
// Ports:
//   i_op    [1:0]      01 csrrw, 10 csrrs, 11 csrrc
//   i_old   [XLEN-1:0] current CSR value
//   i_src   [XLEN-1:0] rs1 or zimm operand
//   o_wdata [XLEN-1:0] new CSR value
// ---------------------------------------------------------------------------
module ysyx_22051013_csr_alu
  import ysyx_22051013_trap_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_old,
  input  logic [XLEN-1:0] i_src,
  output logic [XLEN-1:0] o_wdata
);

  always_comb begin
    o_wdata = i_old;
    case (i_op)
      OP_RW:   o_wdata = i_src;
      OP_RS:   o_wdata = i_old | i_src;
      OP_RC:   o_wdata = i_old & ~i_src;
      // 2'b00 is not a legal op; leave the CSR unchanged.
      default: o_wdata = i_old;
    endcase
  end

endmodule

// File: rtl/ysyx_22051013_trap_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22051013_trap_ctrl
// Sequencing master for the machine-mode CSR file. Takes ECALL / MRET / CSR
// instruction requests from execute, drives the CSR file command port over a
// fixed multi-cycle sequence, returns the old CSR value for rd or a PC
// redirect (which doubles as flush), and stalls IF/ID while busy.
//
// Optional feature macro: YSYX_22051013_TRAP_IRQ_EN
//   defined   : a pending, enabled timer interrupt preempts a request seen in
//               IDLE (request not consumed; it replays after the redirect).
//   undefined : i_mtip / i_irq_enable are ignored.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   i_req_valid/o_req_ready   request handshake (ready only in IDLE)
//   i_req_ecall/_mret/_csr    request kind (priority ecall > mret > csr)
//   i_req_csr_op [1:0]    01 rw, 10 rs, 11 rc
//   i_req_csr_nowr        skip the write phase
//   i_req_csr_addr [11:0] CSR number
//   i_req_src, i_req_pc   operand and instruction PC
//   o_csr_ctl [3:0]       {wr, rd, ecall, mret} command to CSR file
//   o_csr_addr, o_write_csr_data, o_mcause_value   command payload
//   i_read_csr_data       combinational read data from CSR file
//   o_stall               high whenever not IDLE
//   o_done, o_rd_wen, o_rd_wdata   completion / rd writeback
//   o_redirect_valid, o_redirect_pc   PC redirect + flush
//   i_mtip, i_irq_enable  timer pending / enabled
//
// State table:
//   S_IDLE   | ready for a request; csr_ctl = 0
//   S_CSR_RD | read phase of a CSR instruction, capture old value
//   S_CSR_WR | write phase of a CSR instruction, rd writeback
//   S_TRAP   | write mepc/mcause, CSR file presents mtvec
//   S_RET    | mret command, CSR file presents mepc
//   S_REDIR  | redirect pulse to the captured target
// ---------------------------------------------------------------------------
module ysyx_22051013_trap_ctrl
  import ysyx_22051013_trap_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] ECALL_CAUSE = XLEN'(MCAUSE_ECALL_M)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_ecall,
  input  logic            i_req_mret,
  input  logic            i_req_csr,
  input  logic [1:0]      i_req_csr_op,
  input  logic            i_req_csr_nowr,
  input  logic [11:0]     i_req_csr_addr,
  input  logic [XLEN-1:0] i_req_src,
  input  logic [XLEN-1:0] i_req_pc,
  output logic [3:0]      o_csr_ctl,
  output logic [11:0]     o_csr_addr,
  output logic [XLEN-1:0] o_write_csr_data,
  output logic [XLEN-1:0] o_mcause_value,
  input  logic [XLEN-1:0] i_read_csr_data,
  output logic            o_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_rd_wdata,
  output logic            o_rd_wen,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc,
  input  logic            i_mtip,
  input  logic            i_irq_enable
);

  trap_state_e     r_state;
  trap_state_e     w_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_src;
  logic [XLEN-1:0] r_old;
  logic [XLEN-1:0] r_target;
  logic [11:0]     r_addr;
  logic [1:0]      r_op;
  logic            r_nowr;
  logic            r_irq;
  logic            w_irq_take;
  logic            w_accept;
  logic [XLEN-1:0] w_alu_wdata;

`ifdef YSYX_22051013_TRAP_IRQ_EN
  // Only sampled in IDLE, so an interrupt raised mid-sequence waits for IDLE.
  assign w_irq_take = i_mtip & i_irq_enable & i_req_valid;
`else
  // Pins kept for a uniform interface; the interrupt path is compiled out.
  assign w_irq_take = 1'b0 & i_mtip & i_irq_enable;
`endif

  assign w_accept = i_req_valid & ~w_irq_take &
                    (i_req_ecall | i_req_mret | i_req_csr);

  assign o_stall  = (r_state != S_IDLE);

  ysyx_22051013_csr_alu #(
    .XLEN (XLEN)
  ) u_csr_alu (
    .i_op    (r_op),
    .i_old   (r_old),
    .i_src   (r_src),
    .o_wdata (w_alu_wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_src    <= '0;
      r_old    <= '0;
      r_target <= '0;
      r_addr   <= '0;
      r_op     <= '0;
      r_nowr   <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_irq_take) begin
            r_pc  <= i_req_pc;
            r_irq <= 1'b1;
          end else if (w_accept) begin
            r_pc   <= i_req_pc;
            r_src  <= i_req_src;
            r_addr <= i_req_csr_addr;
            r_op   <= i_req_csr_op;
            r_nowr <= i_req_csr_nowr;
            r_irq  <= 1'b0;
          end
        end
        S_CSR_RD: r_old    <= i_read_csr_data;
        // Direct mode only: the low two bits of mtvec are the mode field.
        S_TRAP:   r_target <= {i_read_csr_data[XLEN-1:2], 2'b00};
        S_RET:    r_target <= i_read_csr_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next           = r_state;
    o_req_ready      = 1'b0;
    o_csr_ctl        = CTL_NONE;
    o_csr_addr       = '0;
    o_write_csr_data = '0;
    o_mcause_value   = '0;
    o_done           = 1'b0;
    o_rd_wen         = 1'b0;
    o_rd_wdata       = '0;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = '0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (w_irq_take)                   w_next = S_TRAP;
        else if (i_req_valid & i_req_ecall) w_next = S_TRAP;
        else if (i_req_valid & i_req_mret)  w_next = S_RET;
        else if (i_req_valid & i_req_csr)   w_next = S_CSR_RD;
      end
      S_CSR_RD: begin
        o_csr_ctl  = CTL_RD;
        o_csr_addr = r_addr;
        if (r_nowr) begin
          // Read-only form finishes here; the read data is already the old value.
          o_done     = 1'b1;
          o_rd_wen   = 1'b1;
          o_rd_wdata = i_read_csr_data;
          w_next     = S_IDLE;
        end else begin
          w_next = S_CSR_WR;
        end
      end
      S_CSR_WR: begin
        o_csr_ctl        = CTL_WR;
        o_csr_addr       = r_addr;
        o_write_csr_data = w_alu_wdata;
        o_done           = 1'b1;
        o_rd_wen         = 1'b1;
        o_rd_wdata       = r_old;
        w_next           = S_IDLE;
      end
      S_TRAP: begin
        o_csr_ctl        = CTL_ECALL;
        o_csr_addr       = CSR_MTVEC;
        o_write_csr_data = r_pc;
        o_mcause_value   = r_irq ? XLEN'(MCAUSE_M_TIMER) : ECALL_CAUSE;
        w_next           = S_REDIR;
      end
      S_RET: begin
        o_csr_ctl  = CTL_MRET;
        o_csr_addr = CSR_MEPC;
        w_next     = S_REDIR;
      end
      S_REDIR: begin
        o_redirect_valid = 1'b1;
        o_redirect_pc    = r_target;
        // An interrupt did not consume the request, so it must not complete it.
        o_done           = ~r_irq;
        w_next           = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22051013_trap_ctrl.sv
module tb_ysyx_22051013_trap_ctrl;

  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_ecall, req_mret, req_csr;
  logic [1:0]  req_csr_op;
  logic        req_csr_nowr;
  logic [11:0] req_csr_addr;
  logic [63:0] req_src, req_pc;
  logic [3:0]  csr_ctl;
  logic [11:0] csr_addr;
  logic [63:0] write_csr_data, mcause_value, read_csr_data;
  logic        stall, done, rd_wen, redirect_valid;
  logic [63:0] rd_wdata, redirect_pc;
  logic        mtip, irq_enable;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_22051013_trap_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .i_req_valid      (req_valid),
    .o_req_ready      (req_ready),
    .i_req_ecall      (req_ecall),
    .i_req_mret       (req_mret),
    .i_req_csr        (req_csr),
    .i_req_csr_op     (req_csr_op),
    .i_req_csr_nowr   (req_csr_nowr),
    .i_req_csr_addr   (req_csr_addr),
    .i_req_src        (req_src),
    .i_req_pc         (req_pc),
    .o_csr_ctl        (csr_ctl),
    .o_csr_addr       (csr_addr),
    .o_write_csr_data (write_csr_data),
    .o_mcause_value   (mcause_value),
    .i_read_csr_data  (read_csr_data),
    .o_stall          (stall),
    .o_done           (done),
    .o_rd_wdata       (rd_wdata),
    .o_rd_wen         (rd_wen),
    .o_redirect_valid (redirect_valid),
    .o_redirect_pc    (redirect_pc),
    .i_mtip           (mtip),
    .i_irq_enable     (irq_enable)
  );

  // Small CSR file model: combinational read, commands applied at posedge.
  logic [63:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
  logic        pre_en;
  logic [11:0] pre_addr;
  logic [63:0] pre_val;

  always_comb begin
    read_csr_data = 64'h0;
    case (csr_addr)
      12'h300: read_csr_data = m_mstatus;
      12'h305: read_csr_data = m_mtvec;
      12'h341: read_csr_data = m_mepc;
      12'h342: read_csr_data = m_mcause;
      default: read_csr_data = 64'h0;
    endcase
  end

  always @(posedge clk) begin
    if (pre_en) begin
      case (pre_addr)
        12'h300: m_mstatus <= pre_val;
        12'h305: m_mtvec   <= pre_val;
        12'h341: m_mepc    <= pre_val;
        12'h342: m_mcause  <= pre_val;
        default: ;
      endcase
    end else if (csr_ctl == 4'b1000) begin
      case (csr_addr)
        12'h300: m_mstatus <= write_csr_data;
        12'h305: m_mtvec   <= write_csr_data;
        12'h341: m_mepc    <= write_csr_data;
        12'h342: m_mcause  <= write_csr_data;
        default: ;
      endcase
    end else if (csr_ctl == 4'b0010) begin
      m_mepc   <= write_csr_data;
      m_mcause <= mcause_value;
    end
  end

  function automatic logic [63:0] mread(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 64'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    bit ecall, mret, csr; logic [1:0] op; bit nowr; logic [11:0] addr;
    logic [63:0] src, pc;
    logic [11:0] pre_addr; logic [63:0] pre_val;
    logic [3:0] ctl1; logic [11:0] addr1; logic [63:0] wd1, mc1; bit done1; logic [63:0] rd1;
    logic [3:0] ctl2; logic [11:0] addr2; logic [63:0] wd2; bit done2, rdwen2;
    logic [63:0] rd2; bit redir2; logic [63:0] rpc2;
    logic [11:0] fin_addr; logic [63:0] fin_val;
  } vec_t;

  vec_t vecs[12];

  task automatic preload(input logic [11:0] a, input logic [63:0] v);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_val = v;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic drive(input bit e, input bit m, input bit c, input logic [1:0] op,
                       input bit nowr, input logic [11:0] a, input logic [63:0] s,
                       input logic [63:0] pc);
    req_ecall = e; req_mret = m; req_csr = c; req_csr_op = op;
    req_csr_nowr = nowr; req_csr_addr = a; req_src = s; req_pc = pc;
    req_valid = 1'b1;
  endtask

  task automatic apply(input int i, input vec_t v);
    preload(v.pre_addr, v.pre_val);
    drive(v.ecall, v.mret, v.csr, v.op, v.nowr, v.addr, v.src, v.pc);
    @(posedge clk); #1;
    chk($sformatf("v%0d p1 ctl", i),    64'(csr_ctl), 64'(v.ctl1));
    chk($sformatf("v%0d p1 addr", i),   64'(csr_addr), 64'(v.addr1));
    chk($sformatf("v%0d p1 wdata", i),  write_csr_data, v.wd1);
    chk($sformatf("v%0d p1 mcause", i), mcause_value, v.mc1);
    chk($sformatf("v%0d p1 done", i),   64'(done), 64'(v.done1));
    chk($sformatf("v%0d p1 rd_wen", i), 64'(rd_wen), 64'(v.done1));
    chk($sformatf("v%0d p1 rd_wdata", i), rd_wdata, v.rd1);
    chk($sformatf("v%0d p1 redir", i),  64'(redirect_valid), 64'(0));
    chk($sformatf("v%0d p1 stall", i),  64'(stall), 64'(1));
    chk($sformatf("v%0d p1 ready", i),  64'(req_ready), 64'(0));
    if (v.done1) begin
      req_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      chk($sformatf("v%0d p2 ctl", i),    64'(csr_ctl), 64'(v.ctl2));
      chk($sformatf("v%0d p2 addr", i),   64'(csr_addr), 64'(v.addr2));
      chk($sformatf("v%0d p2 wdata", i),  write_csr_data, v.wd2);
      chk($sformatf("v%0d p2 done", i),   64'(done), 64'(v.done2));
      chk($sformatf("v%0d p2 rd_wen", i), 64'(rd_wen), 64'(v.rdwen2));
      chk($sformatf("v%0d p2 rd_wdata", i), rd_wdata, v.rd2);
      chk($sformatf("v%0d p2 redir", i),  64'(redirect_valid), 64'(v.redir2));
      chk($sformatf("v%0d p2 rpc", i),    redirect_pc, v.rpc2);
      chk($sformatf("v%0d p2 stall", i),  64'(stall), 64'(1));
      req_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk($sformatf("v%0d idle stall", i), 64'(stall), 64'(0));
    chk($sformatf("v%0d idle ready", i), 64'(req_ready), 64'(1));
    chk($sformatf("v%0d idle done", i),  64'(done), 64'(0));
    chk($sformatf("v%0d idle ctl", i),   64'(csr_ctl), 64'(0));
    chk($sformatf("v%0d final csr", i),  mread(v.fin_addr), v.fin_val);
  endtask

  initial begin
    // csrrw mtvec
    vecs[0]  = '{N,N,Y,2'b01,N,12'h305,64'h8000_0100,64'h8000_0000, 12'h305,64'h0,
                 4'b0100,12'h305,64'h0,64'h0,N,64'h0,
                 4'b1000,12'h305,64'h8000_0100,Y,Y,64'h0,N,64'h0, 12'h305,64'h8000_0100};
    // csrrs mstatus, rs1=x0: read only
    vecs[1]  = '{N,N,Y,2'b10,Y,12'h300,64'h0,64'h8000_0004, 12'h300,64'h1800,
                 4'b0100,12'h300,64'h0,64'h0,Y,64'h1800,
                 4'b0000,12'h000,64'h0,N,N,64'h0,N,64'h0, 12'h300,64'h1800};
    // csrrs mstatus |= 8
    vecs[2]  = '{N,N,Y,2'b10,N,12'h300,64'h8,64'h8000_0008, 12'h300,64'h1800,
                 4'b0100,12'h300,64'h0,64'h0,N,64'h0,
                 4'b1000,12'h300,64'h1808,Y,Y,64'h1800,N,64'h0, 12'h300,64'h1808};
    // csrrc mstatus &= ~0x800
    vecs[3]  = '{N,N,Y,2'b11,N,12'h300,64'h800,64'h8000_000c, 12'h300,64'h1808,
                 4'b0100,12'h300,64'h0,64'h0,N,64'h0,
                 4'b1000,12'h300,64'h1008,Y,Y,64'h1808,N,64'h0, 12'h300,64'h1008};
    // csrrc mcause, read only
    vecs[4]  = '{N,N,Y,2'b11,Y,12'h342,64'h0,64'h8000_0010, 12'h342,64'h11,
                 4'b0100,12'h342,64'h0,64'h0,Y,64'h11,
                 4'b0000,12'h000,64'h0,N,N,64'h0,N,64'h0, 12'h342,64'h11};
    // csrrw mepc
    vecs[5]  = '{N,N,Y,2'b01,N,12'h341,64'h1234,64'h8000_0014, 12'h341,64'hdead,
                 4'b0100,12'h341,64'h0,64'h0,N,64'h0,
                 4'b1000,12'h341,64'h1234,Y,Y,64'hdead,N,64'h0, 12'h341,64'h1234};
    // ecall, mtvec low bits masked
    vecs[6]  = '{Y,N,N,2'b00,N,12'h000,64'h0,64'h8000_0040, 12'h305,64'h8000_0103,
                 4'b0010,12'h305,64'h8000_0040,64'd11,N,64'h0,
                 4'b0000,12'h000,64'h0,Y,N,64'h0,Y,64'h8000_0100, 12'h341,64'h8000_0040};
    // mret
    vecs[7]  = '{N,Y,N,2'b00,N,12'h000,64'h0,64'h8000_0048, 12'h341,64'h8000_0044,
                 4'b0001,12'h341,64'h0,64'h0,N,64'h0,
                 4'b0000,12'h000,64'h0,Y,N,64'h0,Y,64'h8000_0044, 12'h341,64'h8000_0044};
    // all kinds set: ecall wins
    vecs[8]  = '{Y,Y,Y,2'b01,N,12'h300,64'hff,64'h100, 12'h305,64'h203,
                 4'b0010,12'h305,64'h100,64'd11,N,64'h0,
                 4'b0000,12'h000,64'h0,Y,N,64'h0,Y,64'h200, 12'h341,64'h100};
    // mret + csr: mret wins, mepc not masked
    vecs[9]  = '{N,Y,Y,2'b01,N,12'h300,64'hff,64'h44, 12'h341,64'h3000_0006,
                 4'b0001,12'h341,64'h0,64'h0,N,64'h0,
                 4'b0000,12'h000,64'h0,Y,N,64'h0,Y,64'h3000_0006, 12'h341,64'h3000_0006};
    // csrrw with nowr: write suppressed even for rw
    vecs[10] = '{N,N,Y,2'b01,Y,12'h305,64'h99,64'h50, 12'h305,64'h77,
                 4'b0100,12'h305,64'h0,64'h0,Y,64'h77,
                 4'b0000,12'h000,64'h0,N,N,64'h0,N,64'h0, 12'h305,64'h77};
    // csrrc mtvec 0xff & ~0x0f
    vecs[11] = '{N,N,Y,2'b11,N,12'h305,64'h0f,64'h54, 12'h305,64'hff,
                 4'b0100,12'h305,64'h0,64'h0,N,64'h0,
                 4'b1000,12'h305,64'hf0,Y,Y,64'hff,N,64'h0, 12'h305,64'hf0};

    rst = 1'b1; pre_en = 1'b0; pre_addr = 12'h0; pre_val = 64'h0;
    mtip = 1'b0; irq_enable = 1'b0;
    drive(N, N, N, 2'b00, N, 12'h0, 64'h0, 64'h0);
    req_valid = 1'b0;
    #1;
    chk("rst ready", 64'(req_ready), 64'(1));
    chk("rst ctl",   64'(csr_ctl), 64'(0));
    chk("rst stall", 64'(stall), 64'(0));
    chk("rst done",  64'(done), 64'(0));
    chk("rst rd_wen", 64'(rd_wen), 64'(0));
    chk("rst redir", 64'(redirect_valid), 64'(0));
    chk("rst rpc",   redirect_pc, 64'h0);
    chk("rst rd_wdata", rd_wdata, 64'h0);
    @(negedge clk); rst = 1'b0;
    preload(12'h300, 64'h0); preload(12'h305, 64'h0);
    preload(12'h341, 64'h0); preload(12'h342, 64'h0);

    for (int i = 0; i < 12; i++) apply(i, vecs[i]);

    // Valid without any request kind is not accepted.
    @(negedge clk);
    drive(N, N, N, 2'b01, N, 12'h300, 64'h1, 64'h0);
    @(posedge clk); #1;
    chk("nokind stall", 64'(stall), 64'(0));
    chk("nokind ctl",   64'(csr_ctl), 64'(0));
    req_valid = 1'b0;

    // Reset during CSR_WR aborts the sequence.
    preload(12'h300, 64'h1800);
    drive(N, N, Y, 2'b01, N, 12'h300, 64'h5, 64'h0);
    @(posedge clk); #1;
    chk("rstseq rd ctl", 64'(csr_ctl), 64'(4'b0100));
    @(posedge clk); #1;
    chk("rstseq wr ctl", 64'(csr_ctl), 64'(4'b1000));
    #1 rst = 1'b1;
    #1;
    chk("rstseq ctl",   64'(csr_ctl), 64'(0));
    chk("rstseq done",  64'(done), 64'(0));
    chk("rstseq rd_wen", 64'(rd_wen), 64'(0));
    chk("rstseq stall", 64'(stall), 64'(0));
    req_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rstseq ready", 64'(req_ready), 64'(1));
    chk("rstseq no write", m_mstatus, 64'h1800);

`ifdef YSYX_22051013_TRAP_IRQ_EN
    begin
      int c;
      preload(12'h305, 64'h8000_0200);
      preload(12'h300, 64'h0);
      mtip = 1'b1; irq_enable = 1'b1;
      drive(N, N, Y, 2'b01, N, 12'h300, 64'h88, 64'h8000_0050);
      @(posedge clk); #1;
      chk("irq trap ctl", 64'(csr_ctl), 64'(4'b0010));
      chk("irq mcause",   mcause_value, 64'h8000_0000_0000_0007);
      chk("irq mepc data", write_csr_data, 64'h8000_0050);
      @(posedge clk); #1;
      chk("irq redir", 64'(redirect_valid), 64'(1));
      chk("irq rpc",   redirect_pc, 64'h8000_0200);
      chk("irq no done", 64'(done), 64'(0));
      irq_enable = 1'b0; mtip = 1'b0;
      c = 0;
      while (!done && c < 6) begin
        @(posedge clk); #1;
        c++;
      end
      chk("irq replay done", 64'(done), 64'(1));
      chk("irq replay ctl",  64'(csr_ctl), 64'(4'b1000));
      chk("irq replay wdata", write_csr_data, 64'h88);
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("irq mepc", m_mepc, 64'h8000_0050);
      chk("irq mstatus", m_mstatus, 64'h88);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
